cute_lock_step_fsm: RTL
=======================

// Module: cute_lock_step_fsm
// PURPOSE
//   Parametrised, key-locked step-sequencer FSM. It is the generalised successor of the fixed small-FSM
//   controller benchmarks: configurable step count, four walk modes, and a hold/resume handshake.
//   A time-based key unit gates correct behaviour. A wrong key sequence makes the sequencer emit
//   corrupted step outputs and never complete. It sits as a locked control FSM under the benchmark top.
// PARAMETERS
//   N_STEPS      8             number of sequencer steps = width of y (2..32)
//   KEY_W        4             key input width per cycle
//   KEY_CYCLES   4             number of key samples taken after reset (1..16)
//   KEY_SEQ      16'hA5C3      expected keys; sample k compared to KEY_SEQ[k*KEY_W +: KEY_W]
//   CORRUPT_MASK 32'h5A5A5A5A  XOR mask on y when locked; N_STEPS LSBs used
// PORTS
//   clk       in   1          clock; all state changes on rising edge
//   rst       in   1          reset, synchronous, active-low
//   start     in   1          begin a sequence (sampled in IDLE only)
//   mode      in   2          walk mode, captured with start
//   hold      in   1          pause request while running
//   key       in   KEY_W      key sample input during key phase
//   y         out  N_STEPS    current step output (one-hot when unlocked)
//   busy      out  1          high in RUN or HOLD
//   done      out  1          one-cycle pulse on sequence completion
//   locked    out  1          key check failed (valid when key_done=1)
//   key_done  out  1          key phase complete
// BEHAVIOUR
//   Reset (rst=0 at edge): state=IDLE, kcnt=0, bad=0. Outputs y=0, busy=0, done=0, locked=0, key_done=0.
//   Reset mid-operation aborts the sequence and re-enters the key phase.
//   Key phase:
//     - While kcnt<KEY_CYCLES, each edge compares key to slice kcnt; a mismatch sets sticky bad; kcnt++.
//     - After the KEY_CYCLES-th sample, key_done=1 and locked=bad. Both hold until the next reset.
//     - Before key_done, start is ignored and the FSM stays in IDLE.
//   States: IDLE, RUN, HOLD, DONE. idx is 5 bits; mode is captured as cmode.
//   IDLE: start=1 and key_done=1 -> RUN, idx=first(mode), cmode=mode. hold is ignored; start wins if both are high.
//   Walk modes:
//     00 forward: 0..N-1
//     01 reverse: N-1..0
//     10 even steps: 0,2,..,last even (N-1 if N odd, else N-2)
//     11 single step: 0 only
//   RUN:
//     - y = (1<<idx), XOR CORRUPT_MASK when locked. busy=1.
//     - hold=1 at an edge -> HOLD, idx kept (the current step counts as emitted).
//     - Otherwise, if idx is the last step of cmode: go to DONE when unlocked; when locked, wrap idx to first(cmode) and stay in RUN.
//     - Otherwise idx advances per cmode.
//   HOLD: y=0, busy=1. hold=0 -> RUN at idx+next (resume at the following step); hold=1 -> stay.
//   DONE: done=1, y=0, busy=0, one cycle, then -> IDLE. start is ignored in DONE.
//   Locked: done never asserts. Only reset exits RUN/HOLD.
//   Latency:
//     - start sampled at edge k -> first step visible in cycle k+1.
//     - Unlocked forward run: done at cycle k+N_STEPS+1.
//   Outputs are decoded from registered state only (Moore); no input-to-output combinational path.
// TESTING (N_STEPS=8, KEY_W=4, KEY_CYCLES=4, defaults)
//   1 Reset, then keys 3,C,5,A on 4 edges -> key_done=1 after 4th edge, locked=0; start before that ignored.
//   2 Unlocked, start mode=00 -> y=01,02,04,08,10,20,40,80 on consecutive cycles, then done=1 one cycle, busy=0.
//   3 mode=01 -> y=80..01 then done. mode=10 -> y=01,04,10,40 then done. mode=11 -> y=01 then done.
//   4 mode=00, hold=1 while y=04, for 3 edges -> y=00 x3, then 08 resumes; done 12 cycles after start.
//   5 Keys 3,C,5,B -> locked=1. mode=00 -> y=5B,58,5E,52,4A,7A,1A,DA, then repeats; done=0 for 32 cycles.
//   6 rst=0 while y=20 -> next cycle y=0, busy=0, key_done=0; start ignored until 4 new key samples.

Source files
------------

// File: rtl/cute_lock_step_fsm.sv
// Key-locked step sequencer: a key phase after reset qualifies the FSM; a wrong key
// corrupts the emitted steps and prevents the sequence from ever completing.
module cute_lock_step_fsm #(
    parameter int                           N_STEPS      = 8,
    parameter int                           KEY_W        = 4,
    parameter int                           KEY_CYCLES   = 4,
    parameter logic [KEY_CYCLES*KEY_W-1:0]  KEY_SEQ      = 16'hA5C3,
    parameter logic [31:0]                  CORRUPT_MASK = 32'h5A5A5A5A
) (
    input  logic               clk_i,
    input  logic               rst_i,
    input  logic               start_i,
    input  logic [1:0]         mode_i,
    input  logic               hold_i,
    input  logic [KEY_W-1:0]   key_i,
    output logic [N_STEPS-1:0] y_o,
    output logic               busy_o,
    output logic               done_o,
    output logic               locked_o,
    output logic               key_done_o
);
    localparam int         KCW       = $clog2(KEY_CYCLES + 1);
    localparam logic [4:0] LAST_IDX  = 5'(N_STEPS - 1);
    localparam logic [4:0] LAST_EVEN = 5'((N_STEPS % 2 == 1) ? N_STEPS - 1 : N_STEPS - 2);

    localparam logic [1:0] M_FWD = 2'b00, M_REV = 2'b01, M_EVEN = 2'b10, M_ONE = 2'b11;

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_HOLD, S_DONE} state_t;

    state_t           state_q, state_d;
    logic [4:0]       idx_q, idx_d;
    logic [1:0]       cmode_q, cmode_d;
    logic [KCW-1:0]   kcnt_q, kcnt_d;
    logic             bad_q, bad_d;
    logic [KEY_W-1:0] key_exp;
    logic             key_done, locked, at_last;

    function automatic logic [4:0] first_of(input logic [1:0] m);
        return (m == M_REV) ? LAST_IDX : 5'd0;
    endfunction

    function automatic logic [4:0] last_of(input logic [1:0] m);
        case (m)
            M_FWD:   return LAST_IDX;
            M_EVEN:  return LAST_EVEN;
            default: return 5'd0;
        endcase
    endfunction

    function automatic logic [4:0] next_of(input logic [1:0] m, input logic [4:0] i);
        case (m)
            M_FWD:   return i + 5'd1;
            M_REV:   return i - 5'd1;
            M_EVEN:  return i + 5'd2;
            default: return i;
        endcase
    endfunction

    assign key_done = (kcnt_q == KCW'(KEY_CYCLES));
    assign locked   = key_done & bad_q;
    assign at_last  = (idx_q == last_of(cmode_q));

    always_comb begin
        key_exp = '0;
        for (int k = 0; k < KEY_CYCLES; k++)
            if (kcnt_q == KCW'(k)) key_exp = KEY_SEQ[k*KEY_W +: KEY_W];
    end

    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            state_q <= S_IDLE;
            idx_q   <= '0;
            cmode_q <= M_FWD;
            kcnt_q  <= '0;
            bad_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            cmode_q <= cmode_d;
            kcnt_q  <= kcnt_d;
            bad_q   <= bad_d;
        end
    end

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        cmode_d = cmode_q;
        kcnt_d  = kcnt_q;
        bad_d   = bad_q;
        if (!key_done) begin
            kcnt_d = kcnt_q + KCW'(1);
            if (key_i != key_exp) bad_d = 1'b1;
        end
        case (state_q)
            S_IDLE: if (start_i && key_done) begin
                state_d = S_RUN;
                idx_d   = first_of(mode_i);
                cmode_d = mode_i;
            end
            S_RUN, S_HOLD: begin
                if (state_q == S_RUN && hold_i) begin
                    state_d = S_HOLD;
                end else if (state_q == S_RUN || !hold_i) begin
                    // A locked sequencer wraps forever instead of finishing.
                    state_d = S_RUN;
                    if (!at_last)     idx_d = next_of(cmode_q, idx_q);
                    else if (locked)  idx_d = first_of(cmode_q);
                    else              state_d = S_DONE;
                end
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        y_o        = '0;
        busy_o     = (state_q == S_RUN) || (state_q == S_HOLD);
        done_o     = (state_q == S_DONE);
        locked_o   = locked;
        key_done_o = key_done;
        if (state_q == S_RUN)
            y_o = (N_STEPS'(1) << idx_q) ^ (locked ? CORRUPT_MASK[N_STEPS-1:0] : '0);
    end
endmodule
